// File: rtl/resp_misr_collector.sv
// resp_misr_collector: folds sampled response vectors into a MISR signature and streams it out byte-serially.
// Ports: clk, rst (async, active-high); start/num_samples begin a run of num_samples absorbs;
// resp_valid/resp_data supply samples; out_valid/out_ready/out_data/out_last carry the signature beats
// (most-significant first); busy is high while collecting or emitting; done pulses after the last beat;
// sample_count reports samples absorbed in the current or last run.
// Define RESP_TRAILER_EN to append sample_count as trailer beats after the signature.
module resp_misr_collector #(
    parameter int             DATA_W = 81,
    parameter int             SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF,
    parameter int             OUT_W  = 8,
    parameter int             CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_count
);
`ifdef RESP_TRAILER_EN
    localparam int NB = SIG_W/OUT_W + CNT_W/OUT_W;
    localparam int EW = SIG_W + CNT_W;
`else
    localparam int NB = SIG_W/OUT_W;
    localparam int EW = SIG_W;
`endif
    localparam int BW  = NB > 1 ? $clog2(NB) : 1;
    localparam int NCH = (DATA_W + SIG_W - 1) / SIG_W;
    localparam int PW  = NCH * SIG_W;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t            state, state_n;
    logic [SIG_W-1:0]  sig, sig_n, fold;
    logic [CNT_W-1:0]  target, cnt_n;
    logic [BW-1:0]     beat;
    logic [PW-1:0]     padded;
    logic [EW-1:0]     word, shifted;
    logic              absorb, accept, final_beat;

    // Zero-extend to whole chunks so the top chunk is padded, then XOR all chunks together.
    always_comb begin
        padded = PW'(resp_data);
        fold   = '0;
        for (int i = 0; i < NCH; i++)
            fold = fold ^ padded[i*SIG_W +: SIG_W];
    end

    assign sig_n      = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    assign absorb     = state == COLLECT && resp_valid;
    assign accept     = state == EMIT && out_ready;
    assign final_beat = beat == BW'(NB - 1);
    assign cnt_n      = sample_count + 1'b1;

`ifdef RESP_TRAILER_EN
    assign word = {sig, sample_count};
`else
    assign word = sig;
`endif

    always_comb begin
        state_n   = state;
        shifted   = word << (OUT_W * beat);
        out_valid = state == EMIT;
        busy      = state != IDLE;
        out_last  = out_valid && final_beat;
        out_data  = out_valid ? shifted[EW-1 -: OUT_W] : '0;
        if (state == IDLE && start)
            state_n = num_samples != '0 ? COLLECT : EMIT;
        else if (absorb && cnt_n == target)
            state_n = EMIT;
        else if (accept && final_beat)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sig          <= SEED;
            sample_count <= '0;
            target       <= '0;
            beat         <= '0;
            done         <= 1'b0;
        end else begin
            state <= state_n;
            done  <= accept && final_beat;
            if (state == IDLE && start) begin
                target       <= num_samples;
                sig          <= SEED;
                sample_count <= '0;
                beat         <= '0;
            end
            if (absorb) begin
                sig          <= sig_n;
                sample_count <= cnt_n;
            end
            if (accept)
                beat <= final_beat ? '0 : beat + 1'b1;
        end
    end
endmodule

// File: tb/tb_resp_misr_collector.sv
// tb_resp_misr_collector: directed self-checking bench for resp_misr_collector.
module tb_resp_misr_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        resp_valid = 1'b0;
    logic [80:0] resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] sample_count;
    int          vectors = 0;
    int          errs = 0;

    resp_misr_collector dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .resp_valid(resp_valid), .resp_data(resp_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [15:0] n);
        num_samples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drains the whole emit sequence with out_ready high and checks every beat plus done.
    task automatic emit_check(input string tag, input logic [31:0] s, input logic [15:0] c);
        logic [47:0] w;
        int          n;
`ifdef RESP_TRAILER_EN
        w = {s, c};
        n = 6;
`else
        w = {s, 16'h0};
        n = 4;
`endif
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, 32'(out_data), 32'(w[47-8*k -: 8]));
            chk({tag, "_last"}, 32'(out_last), 32'(k == n - 1));
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_valid_off"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(sample_count), 32'(c));
        tick();
        chk({tag, "_done_off"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        go(16'd0);
        chk("n0_busy", 32'(busy), 32'd1);
        emit_check("n0", 32'hFFFFFFFF, 16'd0);

        go(16'd1);
        chk("n1z_collect_busy", 32'(busy), 32'd1);
        chk("n1z_collect_novalid", 32'(out_valid), 32'd0);
        resp_valid = 1'b1;
        resp_data = '0;
        tick();
        resp_valid = 1'b0;
        emit_check("n1z", 32'hFB3EE249, 16'd1);

        go(16'd1);
        resp_valid = 1'b1;
        resp_data = 81'h1;
        tick();
        resp_valid = 1'b0;
        emit_check("n1b0", 32'hFB3EE248, 16'd1);

        go(16'd1);
        resp_valid = 1'b1;
        resp_data = 81'h1 << 64;
        tick();
        resp_valid = 1'b0;
        chk("bp_b1", 32'(out_data), 32'hFB);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_stall_data", 32'(out_data), 32'h3E);
            chk("bp_stall_valid", 32'(out_valid), 32'd1);
            chk("bp_stall_last", 32'(out_last), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_b2", 32'(out_data), 32'h3E);
        tick();
        chk("bp_b3", 32'(out_data), 32'hE2);
        tick();
        chk("bp_b4", 32'(out_data), 32'h48);
`ifndef RESP_TRAILER_EN
        chk("bp_b4_last", 32'(out_last), 32'd1);
`endif
        tick();
`ifdef RESP_TRAILER_EN
        chk("bp_t1", 32'(out_data), 32'h00);
        tick();
        chk("bp_t2", 32'(out_data), 32'h01);
        chk("bp_t2_last", 32'(out_last), 32'd1);
        tick();
`endif
        chk("bp_done", 32'(done), 32'd1);
        tick();

        resp_valid = 1'b1;
        resp_data = 81'h5;
        tick();
        chk("idle_ignore_count", 32'(sample_count), 32'd1);
        chk("idle_ignore_busy", 32'(busy), 32'd0);

        resp_data = '0;
        resp_valid = 1'b0;
        go(16'd3);
        num_samples = 16'd9;
        for (int k = 0; k < 5; k++) begin
            resp_valid = k % 2 == 0;
            start = k % 2 == 1;
            tick();
        end
        start = 1'b0;
        chk("tog_count", 32'(sample_count), 32'd3);
        resp_valid = 1'b1;
        resp_data = 81'h123;
        emit_check("tog", 32'hE1B8AFFD, 16'd3);
        resp_valid = 1'b0;

        go(16'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_data", 32'(out_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_nodone", 32'(done), 32'd0);
        go(16'd0);
        emit_check("after_abort", 32'hFFFFFFFF, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/resp_misr_collector.md
Name: resp_misr_collector

Overview:
- Response-side counterpart to the fuzz stimulus path: consumes the wide `y` result vector of a generated top, one sample per accepted cycle.
- Compresses a programmed number of samples into a MISR signature.
- Streams the signature out byte-serially over a valid/ready handshake.
- Sits between the DUT output and the equivalence-check harness, so two synthesized netlists are compared by signature instead of cycle by cycle.

Parameters:
- DATA_W, 81, width of the response vector `y` being sampled.
- SIG_W, 32, MISR signature width; must be a multiple of OUT_W.
- POLY, 32'h04C11DB7, MISR feedback polynomial (SIG_W bits).
- SEED, 32'hFFFFFFFF, signature value loaded on start and on reset.
- OUT_W, 8, output stream beat width.
- CNT_W, 16, sample counter width; must be a multiple of OUT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a collection run when idle.
- num_samples  in  CNT_W  samples to absorb; latched on an accepted start.
- resp_valid  in  1  resp_data valid this cycle.
- resp_data  in  DATA_W  response vector sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  OUT_W  signature beat.
- out_last  out  1  final beat of the run.
- busy  out  1  high in COLLECT or EMIT.
- done  out  1  one-cycle pulse after the last beat is accepted.
- sample_count  out  CNT_W  samples absorbed in the current or last run.

Behaviour:
- Reset values (asynchronous; all outputs and state):
  - state IDLE; signature SEED; sample_count 0.
  - out_valid, out_last, busy, done all 0; out_data 0.
- States:
  - IDLE: start=1 latches num_samples, loads SEED, clears sample_count. Next state is COLLECT if num_samples≠0, else EMIT.
  - COLLECT: each cycle with resp_valid=1 absorbs one sample and increments sample_count. When sample_count reaches num_samples on that absorb, next state is EMIT. resp_valid=0 holds state and signature.
  - EMIT: SIG_W/OUT_W beats, most-significant byte first. out_valid=1 throughout. A beat advances only on out_valid&&out_ready. out_data and out_last stay stable while stalled. out_last=1 on the final beat only. Acceptance of the final beat returns to IDLE and pulses done for exactly one cycle.
- Fold: resp_data is split into SIG_W chunks from bit 0 upward, top chunk zero-padded; fold is the XOR of all chunks. For DATA_W=81 that is [31:0]^[63:32]^{15'b0,[80:64]}.
- MISR update, one cycle per absorbed sample, result visible the next cycle:
  - fb = sig[SIG_W-1]
  - sig_next = {sig[SIG_W-2:0],1'b0} ^ (fb ? POLY : 0) ^ fold.
- Latency: first out_valid in the cycle after the absorbing edge of the last sample. For num_samples=0, the cycle after start.
- start while busy is ignored.
- resp_valid in IDLE or EMIT is ignored; no absorb, no count.
- busy=1 exactly in COLLECT and EMIT. done is never high together with out_valid.
- sample_count keeps its value after the run until the next accepted start.
- Reset asserted mid-COLLECT or mid-EMIT aborts immediately to reset values. No done pulse.

Optional Feature:
- RESP_TRAILER_EN defined:
  - After the signature beats, EMIT sends CNT_W/OUT_W trailer beats carrying sample_count, MS byte first.
  - out_last moves to the last trailer beat; done follows its acceptance.
- Undefined: signature beats only, as above.

Test Plan:
- num_samples=0, start, out_ready=1 → beats FF,FF,FF,FF; out_last on beat 4; done pulse next cycle; sample_count=0.
- num_samples=1, resp_data=0 → beats FB,3E,E2,49.
- num_samples=1, resp_data=81'h1 → FB,3E,E2,48. Repeat with only bit 64 set → identical FB,3E,E2,48 (fold check).
- Backpressure: run from the previous test with out_ready low for 3 cycles on beat 2 → out_data stays 3E and out_valid stays 1 while stalled; no beat is skipped or duplicated.
- num_samples=3 with resp_valid toggling 1,0,1,0,1 → exactly 3 absorbs, sample_count=3; start pulses during COLLECT and resp_valid during EMIT are ignored. With RESP_TRAILER_EN: trailer 00,03 follows, out_last on 03.
- rst asserted mid-EMIT after beat 2 → out_valid=0 and busy=0 immediately, no done. A new start with num_samples=0 afterwards emits FF,FF,FF,FF.
